// File: rtl/ringy_pkg.sv
// ringy_pkg: shared constants and request record for the ringy cell arbiter.
package ringy_pkg;
    localparam int CELLS      = 10;
    localparam int AW         = 4;
    localparam int DW         = 8;
    localparam int PIPE_DEPTH = 2;
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;
endpackage

// File: rtl/ringy_rr_pick.sv
// ringy_rr_pick: combinational round-robin picker; the first request at or after ptr wins.
module ringy_rr_pick import ringy_pkg::*; #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);
    logic [PW-1:0] w_j;
    // Scan from the far end back towards ptr so the nearest request is assigned last.
    always_comb begin
        w_j   = '0;
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = PW'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j]) o_idx = w_j;
        end
        o_any    = |i_req;
        o_onehot = o_any ? NREQ'(1) << o_idx : '0;
    end
endmodule

// File: rtl/ringy_cell_arbiter.sv
// ringy_cell_arbiter: round-robin arbiter sharing one single-port cell array among NREQ requesters.
// Two-stage pipeline: issue (array strobe) then response (rvalid/rdata/rerr).
module ringy_cell_arbiter import ringy_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int CELLS = ringy_pkg::CELLS,
    parameter int AW    = ringy_pkg::AW,
    parameter int DW    = ringy_pkg::DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_ena,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_rvalid,
    output logic [DW-1:0]      o_rdata,
    output logic               o_rerr,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic [AW-1:0]      o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
    input  logic [DW-1:0]      i_mem_rdata
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]   r_ptr, r_iss_idx, w_idx;
    logic            w_any, w_ok;
    logic            r_mem_en, r_iss_err, r_rsp_err, r_rsp_rd;
    logic [NREQ-1:0] r_rsp_vld;
    req_t            w_rec, r_iss;
    // Gating with rst_n keeps gnt low while reset is held.
    ringy_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req    (i_req & {NREQ{i_ena & rst_n}}),
        .i_ptr    (r_ptr),
        .o_onehot (o_gnt),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );
    assign w_rec = '{we: i_we[w_idx], addr: i_addr[w_idx*AW +: AW], wdata: i_wdata[w_idx*DW +: DW]};
    // Full-width compare so unused upper address bits still flag an error.
    assign w_ok  = 32'(w_rec.addr) < 32'(CELLS);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_mem_en  <= 1'b0;
            r_iss_err <= 1'b0;
            r_iss_idx <= '0;
            r_iss     <= '0;
            r_rsp_vld <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_rd  <= 1'b0;
        end else begin
            if (w_any) r_ptr <= (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            if (w_any) r_iss_idx <= w_idx;
            if (w_any && w_ok) r_iss <= w_rec;
            r_mem_en  <= w_any & w_ok;
            r_iss_err <= w_any & ~w_ok;
            r_rsp_vld <= (r_mem_en | r_iss_err) ? NREQ'(1) << r_iss_idx : '0;
            r_rsp_err <= r_iss_err;
            r_rsp_rd  <= r_mem_en & ~r_iss.we;
        end
    end
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_en & r_iss.we;
    assign o_mem_addr  = r_iss.addr;
    assign o_mem_wdata = r_iss.wdata;
    assign o_rvalid    = r_rsp_vld;
    assign o_rerr      = r_rsp_err;
    assign o_rdata     = r_rsp_rd ? i_mem_rdata : '0;
endmodule

// File: tb/tb_ringy_cell_arbiter.sv
// tb_ringy_cell_arbiter: directed-vector bench for the ringy cell arbiter.
// A small behavioural cell array answers the DUT's memory port one cycle after mem_en.
module tb_ringy_cell_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, ena;
    logic [3:0]  req, we, gnt, rvalid;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [7:0]  rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_addr;
    logic        rerr, mem_en, mem_we;
    logic [7:0]  mem [16];
    int          n_vec = 0;
    int          n_err = 0;

    ringy_cell_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ena       (ena),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_rerr      (rerr),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        rst_n = 1'b0; ena = 1'b1; req = 4'b1111; we = 4'b0000; addr = 16'h0000; wdata = 32'h0;
        tick();
        tick();
        // Reset held with all requests raised
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_rvalid", rvalid, 4'b0000);
        chk("rst_rerr", rerr, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_mem_addr", mem_addr, 4'h0);
        rst_n = 1'b1;
        #1;
        // All requesters: rotate 0,1,2,3,0,1,2,3; responses trail by two cycles
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_gnt%0d", k), gnt, 4'b0001 << (k % 4));
            chk($sformatf("rr_rvalid%0d", k), rvalid, (k >= 2) ? 4'b0001 << ((k - 2) % 4) : 4'b0000);
            tick();
        end
        req = 4'b0000;
        #1;
        chk("rr_idle_gnt", gnt, 4'b0000);
        chk("rr_tail_rv6", rvalid, 4'b0100);
        tick();
        chk("rr_tail_rv7", rvalid, 4'b1000);
        tick();
        chk("rr_tail_none", rvalid, 4'b0000);
        // Requester 2 writes A5 to cell 3, requester 1 reads it back next cycle
        req = 4'b0100; we = 4'b0100; addr = 16'h0300; wdata = 32'h00A5_0000;
        #1;
        chk("wr_gnt", gnt, 4'b0100);
        tick();
        req = 4'b0010; we = 4'b0000; addr = 16'h0030;
        #1;
        chk("rd_gnt", gnt, 4'b0010);
        chk("wr_mem_en", mem_en, 1'b1);
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_addr", mem_addr, 4'h3);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        tick();
        req = 4'b0000;
        #1;
        chk("wr_rvalid", rvalid, 4'b0100);
        chk("wr_rerr", rerr, 1'b0);
        chk("wr_rdata", rdata, 8'h00);
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_we", mem_we, 1'b0);
        tick();
        chk("rd_rvalid", rvalid, 4'b0010);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_rerr", rerr, 1'b0);
        // Requester 3 reads out-of-range cell 12 (pointer now at 2)
        req = 4'b1000; addr = 16'hC000;
        #1;
        chk("oor_rd_gnt", gnt, 4'b1000);
        tick();
        req = 4'b0000;
        #1;
        chk("oor_rd_mem_en", mem_en, 1'b0);
        tick();
        chk("oor_rd_rvalid", rvalid, 4'b1000);
        chk("oor_rd_rerr", rerr, 1'b1);
        chk("oor_rd_rdata", rdata, 8'h00);
        // Requester 0 writes to cell 15: must never reach the array
        req = 4'b0001; we = 4'b0001; addr = 16'h000F; wdata = 32'h0000_005A;
        #1;
        chk("oor_wr_gnt", gnt, 4'b0001);
        tick();
        req = 4'b0000; we = 4'b0000;
        #1;
        chk("oor_wr_mem_en", mem_en, 1'b0);
        chk("oor_wr_mem_we", mem_we, 1'b0);
        tick();
        chk("oor_wr_rvalid", rvalid, 4'b0001);
        chk("oor_wr_rerr", rerr, 1'b1);
        chk("oor_wr_cell", mem[15], 8'h00);
        // Drop ena right after a grant (pointer at 1)
        req = 4'b1111; addr = 16'h1111;
        #1;
        chk("ena_gnt", gnt, 4'b0010);
        tick();
        ena = 1'b0;
        #1;
        chk("ena_off_gnt0", gnt, 4'b0000);
        chk("ena_off_mem_en", mem_en, 1'b1);
        tick();
        chk("ena_off_gnt1", gnt, 4'b0000);
        chk("ena_off_rvalid", rvalid, 4'b0010);
        chk("ena_off_idle", mem_en, 1'b0);
        tick();
        ena = 1'b1;
        #1;
        chk("ena_resume_gnt", gnt, 4'b0100);
        chk("ena_resume_rv", rvalid, 4'b0000);
        tick();
        req = 4'b0000;
        #1;
        chk("ena_resume_mem_en", mem_en, 1'b1);
        tick();
        chk("ena_resume_rvalid", rvalid, 4'b0100);
        // Reset one cycle after a read grant (pointer at 3 -> requester 0 wins)
        req = 4'b0001; addr = 16'h0003;
        #1;
        chk("mid_rst_gnt", gnt, 4'b0001);
        tick();
        req = 4'b0000;
        #1;
        chk("mid_rst_issue", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_rvalid", rvalid, 4'b0000);
        chk("mid_rst_mem_addr", mem_addr, 4'h0);
        tick();
        chk("mid_rst_no_rv", rvalid, 4'b0000);
        chk("mid_rst_rdata", rdata, 8'h00);
        rst_n = 1'b1; req = 4'b1111;
        #1;
        chk("post_rst_gnt", gnt, 4'b0001);
        tick();
        chk("post_rst_gnt2", gnt, 4'b0010);
        req = 4'b0000;
        repeat (ringy_pkg::PIPE_DEPTH + 1) tick();
        chk("drain_rvalid", rvalid, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
